// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave memory bus arbiter: round-robin grant with bounded bursts
// and a forced dead cycle on every ownership change.
module mem_bus_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_rreq,
   input  logic        m0_wreq,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_busy,
   output logic        m0_ack,
   input  logic        m1_rreq,
   input  logic        m1_wreq,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_busy,
   output logic        m1_ack,
   output logic        s_rreq,
   output logic        s_wreq,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_busy,
   input  logic        s_ack
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_e;

   state_e          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            next_owner_q, next_owner_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

   logic req0, req1, owning, own, req_own, req_oth, beat, last_beat;
   logic enter, enter_w;

   assign req0      = m0_rreq | m0_wreq;
   assign req1      = m1_rreq | m1_wreq;
   assign owning    = (state_q == OWN0) || (state_q == OWN1);
   assign own       = (state_q == OWN1);
   assign req_own   = own ? req1 : req0;
   assign req_oth   = own ? req0 : req1;
   assign beat      = owning & req_own & ~s_busy;
   // widened by one bit so the +1 cannot wrap when MAX_BURST fills the counter
   assign last_beat = ({1'b0, beat_cnt_q} + 1'b1) >= {1'b0, MAXC};

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      next_owner_d = next_owner_q;
      beat_cnt_d   = beat_cnt_q;
      enter        = 1'b0;
      enter_w      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               enter   = 1'b1;
               enter_w = (req0 & req1) ? ~last_grant_q : req1;
            end
         end
         OWN0, OWN1: begin
            if (!req_own) begin
               state_d = IDLE;
            end else if (beat) begin
               if (last_beat && req_oth) begin
                  state_d      = GAP;
                  next_owner_d = ~own;
               end else if (beat_cnt_q != MAXC) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (next_owner_q ? req1 : req0) begin
               enter   = 1'b1;
               enter_w = next_owner_q;
            end else if (next_owner_q ? req0 : req1) begin
               enter   = 1'b1;
               enter_w = ~next_owner_q;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (enter) begin
         state_d      = enter_w ? OWN1 : OWN0;
         last_grant_d = enter_w;
         beat_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         next_owner_q <= 1'b0;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         next_owner_q <= next_owner_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   // non-owners see a stall for as long as they keep requesting
   always_comb begin
      s_rreq   = 1'b0;
      s_wreq   = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      m0_rdata = '0;
      m0_ack   = 1'b0;
      m0_busy  = req0;
      m1_rdata = '0;
      m1_ack   = 1'b0;
      m1_busy  = req1;
      if (state_q == OWN0) begin
         s_rreq   = m0_rreq;
         s_wreq   = m0_wreq;
         s_addr   = m0_addr;
         s_wdata  = m0_wdata;
         m0_rdata = s_rdata;
         m0_ack   = s_ack;
         m0_busy  = s_busy;
      end else if (state_q == OWN1) begin
         s_rreq   = m1_rreq;
         s_wreq   = m1_wreq;
         s_addr   = m1_addr;
         s_wdata  = m1_wdata;
         m1_rdata = s_rdata;
         m1_ack   = s_ack;
         m1_busy  = s_busy;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: MAX_BURST=4 and MAX_BURST=1 instances on shared
// stimulus, checked every cycle against an ownership-level reference model.
module tb_mem_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_rreq, m0_wreq, m1_rreq, m1_wreq;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
   logic        s_busy, s_ack;

   logic [31:0] o_m0_rdata [2];
   logic [31:0] o_m1_rdata [2];
   logic [31:0] o_s_addr   [2];
   logic [31:0] o_s_wdata  [2];
   logic        o_m0_busy [2], o_m0_ack [2], o_m1_busy [2], o_m1_ack [2];
   logic        o_s_rreq  [2], o_s_wreq [2];

   int vecs = 0;
   int misc = 0;

   // model: own = -1 idle, 0/1 owner, 2 dead cycle
   int own [2];
   int last [2];
   int nxt [2];
   int beats [2];
   int mb [2] = '{4, 1};
   bit bd0, bd1;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MAX_BURST(4)) u0 (
      .clk(clk), .reset_n(reset_n),
      .m0_rreq(m0_rreq), .m0_wreq(m0_wreq), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(o_m0_rdata[0]), .m0_busy(o_m0_busy[0]), .m0_ack(o_m0_ack[0]),
      .m1_rreq(m1_rreq), .m1_wreq(m1_wreq), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(o_m1_rdata[0]), .m1_busy(o_m1_busy[0]), .m1_ack(o_m1_ack[0]),
      .s_rreq(o_s_rreq[0]), .s_wreq(o_s_wreq[0]), .s_addr(o_s_addr[0]), .s_wdata(o_s_wdata[0]),
      .s_rdata(s_rdata), .s_busy(s_busy), .s_ack(s_ack));

   mem_bus_arbiter #(.MAX_BURST(1)) u1 (
      .clk(clk), .reset_n(reset_n),
      .m0_rreq(m0_rreq), .m0_wreq(m0_wreq), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(o_m0_rdata[1]), .m0_busy(o_m0_busy[1]), .m0_ack(o_m0_ack[1]),
      .m1_rreq(m1_rreq), .m1_wreq(m1_wreq), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(o_m1_rdata[1]), .m1_busy(o_m1_busy[1]), .m1_ack(o_m1_ack[1]),
      .s_rreq(o_s_rreq[1]), .s_wreq(o_s_wreq[1]), .s_addr(o_s_addr[1]), .s_wdata(o_s_wdata[1]),
      .s_rdata(s_rdata), .s_busy(s_busy), .s_ack(s_ack));

   task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp);
      vecs++;
      if (act !== exp) begin
         misc++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      check(nm, {102'b0, act}, {102'b0, exp});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         own[i] = -1; last[i] = 1; nxt[i] = 0; beats[i] = 0;
      end
   endtask

   task automatic grant(input int i, input int w);
      own[i] = w; last[i] = w; beats[i] = 0;
   endtask

   task automatic model_step();
      bit r [2];
      r[0] = m0_rreq | m0_wreq;
      r[1] = m1_rreq | m1_wreq;
      bd0 = (own[0] == 0) && r[0] && !s_busy;
      bd1 = (own[0] == 1) && r[1] && !s_busy;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         if (own[i] == -1) begin
            if (r[0] && r[1]) grant(i, 1 - last[i]);
            else if (r[0]) grant(i, 0);
            else if (r[1]) grant(i, 1);
         end else if (own[i] == 2) begin
            if (r[nxt[i]]) grant(i, nxt[i]);
            else if (r[1 - nxt[i]]) grant(i, 1 - nxt[i]);
            else own[i] = -1;
         end else begin
            int x = own[i];
            if (!r[x]) own[i] = -1;
            else if (!s_busy) begin
               if (beats[i] + 1 >= mb[i] && r[1 - x]) begin
                  own[i] = 2; nxt[i] = 1 - x;
               end else if (beats[i] < mb[i]) beats[i]++;
            end
         end
      end
   endtask

   function automatic logic [133:0] expected(input int i);
      logic rr, ww, b0, a0, b1, a1;
      logic [31:0] ad, wd, rd0, rd1;
      rr = 0; ww = 0; ad = 0; wd = 0;
      rd0 = 0; a0 = 0; b0 = m0_rreq | m0_wreq;
      rd1 = 0; a1 = 0; b1 = m1_rreq | m1_wreq;
      if (own[i] == 0) begin
         rr = m0_rreq; ww = m0_wreq; ad = m0_addr; wd = m0_wdata;
         rd0 = s_rdata; a0 = s_ack; b0 = s_busy;
      end else if (own[i] == 1) begin
         rr = m1_rreq; ww = m1_wreq; ad = m1_addr; wd = m1_wdata;
         rd1 = s_rdata; a1 = s_ack; b1 = s_busy;
      end
      return {rr, ww, ad, wd, rd0, b0, a0, rd1, b1, a1};
   endfunction

   function automatic logic [133:0] actual(input int i);
      return {o_s_rreq[i], o_s_wreq[i], o_s_addr[i], o_s_wdata[i],
              o_m0_rdata[i], o_m0_busy[i], o_m0_ack[i],
              o_m1_rdata[i], o_m1_busy[i], o_m1_ack[i]};
   endfunction

   // compare mid-cycle, then advance the model on the edge
   task automatic tick();
      #4;
      check("outputs_mb4", actual(0), expected(0));
      check("outputs_mb1", actual(1), expected(1));
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic new_req(output logic r, output logic w, output logic [31:0] a, output logic [31:0] d);
      int k;
      k = $urandom_range(0, 5);
      r = (k == 3) || (k == 5);
      w = (k == 4) || (k == 5);
      a = $urandom;
      d = $urandom;
   endtask

   logic [31:0] exp_mb4 [10] = '{32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'h0,
                                 32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'h0};
   logic [31:0] exp_mb1 [10] = '{32'hA0, 32'h0, 32'hB0, 32'h0, 32'hA0,
                                 32'h0, 32'hB0, 32'h0, 32'hA0, 32'h0};

   initial begin
      reset_n = 0;
      {m0_rreq, m0_wreq, m1_rreq, m1_wreq, s_busy, s_ack} = '0;
      {m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata} = '0;
      model_reset();
      @(posedge clk); #1;
      tick(); tick();

      // single m0 read after reset release
      m0_rreq = 1; m0_addr = 32'h100; s_busy = 1; s_ack = 1; reset_n = 1;
      #1;
      chk32("cyc0_m0_busy", {31'b0, o_m0_busy[0]}, 32'd1);
      chk32("cyc0_s_rreq", {31'b0, o_s_rreq[0]}, 32'd0);
      tick();
      chk32("cyc1_s_rreq", {31'b0, o_s_rreq[0]}, 32'd1);
      chk32("cyc1_s_addr", o_s_addr[0], 32'h100);
      chk32("cyc1_busy_pass", {31'b0, o_m0_busy[0]}, 32'd1);
      s_busy = 0; s_rdata = 32'h1234_5678;
      #1;
      chk32("cyc2_m0_rdata", o_m0_rdata[0], 32'h1234_5678);
      chk32("cyc2_m0_ack", {31'b0, o_m0_ack[0]}, 32'd1);
      tick();
      m0_rreq = 0;
      tick();

      // reset, then both masters stream reads: m0 first, bursts with a dead cycle
      reset_n = 0; model_reset();
      m0_rreq = 1; m0_addr = 32'hA0; m1_rreq = 1; m1_addr = 32'hB0; s_busy = 0;
      tick();
      reset_n = 1;
      tick();
      for (int c = 0; c < 10; c++) begin
         chk32($sformatf("rr_mb4_c%0d", c), o_s_addr[0], exp_mb4[c]);
         chk32($sformatf("rr_mb1_c%0d", c), o_s_addr[1], exp_mb1[c]);
         tick();
      end

      // async reset while m1 owns
      begin
         int n = 0;
         while (own[0] != 1 && n < 20) begin tick(); n++; end
         chk32("reach_own1", {31'b0, own[0] == 1}, 32'd1);
      end
      chk32("own1_s_rreq", {31'b0, o_s_rreq[0]}, 32'd1);
      reset_n = 0; model_reset();
      #1;
      chk32("async_rst_rreq", {31'b0, o_s_rreq[0]}, 32'd0);
      chk32("async_rst_wreq", {31'b0, o_s_wreq[0]}, 32'd0);
      tick();
      reset_n = 1;
      tick();
      chk32("tie_after_rst", o_s_addr[0], 32'hA0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (!reset_n) reset_n = 1;
         if (!(m0_rreq | m0_wreq) || bd0) new_req(m0_rreq, m0_wreq, m0_addr, m0_wdata);
         else if ($urandom_range(0, 19) == 0) begin m0_rreq = 0; m0_wreq = 0; end
         if (!(m1_rreq | m1_wreq) || bd1) new_req(m1_rreq, m1_wreq, m1_addr, m1_wdata);
         else if ($urandom_range(0, 19) == 0) begin m1_rreq = 0; m1_wreq = 0; end
         s_busy  = ($urandom_range(0, 2) == 0);
         s_ack   = ($urandom_range(0, 7) != 0);
         s_rdata = $urandom;
         if ($urandom_range(0, 299) == 0) begin
            #2;
            reset_n = 0;
            model_reset();
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
      $finish;
   end
endmodule
